// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and architectural constants.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0]  FETCH_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]  FETCH_NOP_INSTR = 32'h0000_0000;
  localparam int unsigned  FETCH_PC_STEP   = 4;

endpackage

// File: rtl/pc_fetch_unit_skid.sv
// One-entry {pc, instr} holding register for a response that arrives while ID is stalled.
module fetch_skid_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] instr_in,
  output logic         full,
  output logic [W-1:0] pc,
  output logic [W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      full  <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC holder and single-outstanding I-cache requester feeding the IF/ID register.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(FETCH_RESET_PC),
  parameter logic [ADDR_W-1:0] NOP_INSTR = ADDR_W'(FETCH_NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              redirect,
  input  logic              stall,
  output logic              ic_req,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_ready,
  input  logic              ic_valid,
  input  logic [ADDR_W-1:0] ic_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic              if_id_valid,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [ADDR_W-1:0] if_id_instr
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(FETCH_PC_STEP);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, req_pc;
  logic              accept;
  logic              deliver_resp, deliver_skid;
  logic              skid_load, skid_clear, skid_full;
  logic [ADDR_W-1:0] skid_pc, skid_instr;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      case (state)
        WAIT:    state_nxt = ic_valid ? FETCH : DISCARD;
        DISCARD: state_nxt = DISCARD;
        default: state_nxt = FETCH;
      endcase
    end else begin
      case (state)
        FETCH:   state_nxt = accept ? WAIT : FETCH;
        WAIT: begin
          if (ic_valid) state_nxt = stall ? HOLD : (accept ? WAIT : FETCH);
          else          state_nxt = WAIT;
        end
        HOLD:    state_nxt = stall ? HOLD : FETCH;
        DISCARD: state_nxt = ic_valid ? FETCH : DISCARD;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // WAIT may issue the next request in the same cycle its response lands.
  always_comb begin
    ic_req       = 1'b0;
    deliver_resp = 1'b0;
    deliver_skid = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    case (state)
      FETCH: ic_req = !stall && !redirect;
      WAIT: begin
        ic_req       = ic_valid && !stall && !redirect;
        deliver_resp = ic_valid && !stall && !redirect;
        skid_load    = ic_valid && stall && !redirect;
      end
      HOLD: begin
        deliver_skid = !stall && !redirect && skid_full;
        skid_clear   = !stall || redirect;
      end
      default: ;
    endcase
    if (rst) ic_req = 1'b0;
  end

  assign accept  = ic_req && ic_ready;
  assign ic_addr = pc;
  assign pc_out  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (redirect)    pc <= next_pc;
      else if (accept) pc <= pc + STEP;
      if (accept) req_pc <= pc;
    end
  end

  fetch_skid_reg #(.W(ADDR_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .pc_in    (req_pc),
    .instr_in (ic_data),
    .full     (skid_full),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

  // A stall freezes IF/ID unless a redirect flushes it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_pc4   <= STEP;
      if_id_instr <= NOP_INSTR;
    end else if (redirect || !stall) begin
      if (deliver_resp) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= req_pc;
        if_id_pc4   <= req_pc + STEP;
        if_id_instr <= ic_data;
      end else if (deliver_skid) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= skid_pc;
        if_id_pc4   <= skid_pc + STEP;
        if_id_instr <= skid_instr;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench: behavioural I-cache responder plus a transaction-level fetch model.
module tb_pc_fetch_unit;

  localparam int unsigned AW     = 32;
  localparam logic [31:0] T_RPC  = 32'hFFFF_FFFC;
  localparam logic [31:0] T_NOP  = 32'h0000_0013;
  localparam int          NCYC   = 4000;

  logic        clk = 1'b0;
  logic        rst, redirect, stall, ic_ready, ic_valid;
  logic [31:0] next_pc, ic_data;
  logic        ic_req, if_id_valid;
  logic [31:0] ic_addr, pc_out, if_id_pc, if_id_pc4, if_id_instr;

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(AW), .RESET_PC(T_RPC), .NOP_INSTR(T_NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .stall       (stall),
    .ic_req      (ic_req),
    .ic_addr     (ic_addr),
    .ic_ready    (ic_ready),
    .ic_valid    (ic_valid),
    .ic_data     (ic_data),
    .pc_out      (pc_out),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Model of the fetch stage in terms of transactions in flight.
  logic [31:0] m_pc, m_out_pc, m_held_pc, m_held_instr, m_ipc, m_ipc4, m_instr;
  bit          m_out, m_discard, m_held, m_v;
  // Cache responder.
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;

  task automatic model_reset();
    m_pc = T_RPC; m_out = 0; m_discard = 0; m_held = 0;
    m_v = 0; m_ipc = '0; m_ipc4 = 32'd4; m_instr = T_NOP;
  endtask

  task automatic deliver(input logic [31:0] a, input logic [31:0] d);
    m_v = 1; m_ipc = a; m_ipc4 = a + 32'd4; m_instr = d;
  endtask

  bit          fast, r_rst, r_red, r_stall, r_rdy, v, exp_req, acc;
  logic [31:0] d, npc, cur_pc;
  int          stall_left;

  initial begin
    rst = 1; redirect = 0; stall = 0; next_pc = '0;
    ic_ready = 0; ic_valid = 0; ic_data = '0;
    model_reset();
    pend = 0; pend_cnt = 0; pend_addr = '0; stall_left = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      check_val("if_id_valid", 32'(if_id_valid), 32'(m_v));
      check_val("if_id_pc",    if_id_pc,    m_ipc);
      check_val("if_id_pc4",   if_id_pc4,   m_ipc4);
      check_val("if_id_instr", if_id_instr, m_instr);
      check_val("pc_out",      pc_out,      m_pc);

      fast  = (((cyc / 256) % 2) == 0);
      r_rst = (cyc < 2) || (!fast && $urandom_range(0, 99) == 0);
      if (fast) begin
        r_stall = 0; r_red = 0; r_rdy = 1;
      end else begin
        if (stall_left == 0 && $urandom_range(0, 9) == 0) stall_left = $urandom_range(1, 4);
        r_stall = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        r_rdy = ($urandom_range(0, 3) != 0);
        r_red = ($urandom_range(0, 15) == 0);
      end

      if (r_rst) begin
        v = 0;
        if (pend) pend_cnt = 0;
      end else begin
        v = pend && (pend_cnt == 0);
      end
      d = v ? mem_word(pend_addr) : $urandom();
      // A redirect while discarding, on the very cycle the stale reply lands, would wait forever.
      if (v && m_discard && r_red) r_red = 0;
      npc = $urandom();
      if ($urandom_range(0, 3) == 0) npc = 32'hFFFF_FFF0 | (npc & 32'hC);

      rst = r_rst; redirect = r_red; stall = r_stall; next_pc = npc;
      ic_ready = r_rdy; ic_valid = v; ic_data = d;
      #1;

      exp_req = !r_rst && !r_red && !r_stall && !m_held && !m_discard && (!m_out || v);
      check_val("ic_req",  32'(ic_req), 32'(exp_req));
      check_val("ic_addr", ic_addr, m_pc);
      acc    = exp_req && r_rdy;
      cur_pc = m_pc;

      if (r_rst) begin
        model_reset();
      end else if (r_red) begin
        m_discard = (m_out && !v) || m_discard;
        m_out = 0; m_held = 0; m_pc = npc; m_v = 0; m_instr = T_NOP;
      end else begin
        if (m_discard && v) m_discard = 0;
        if (r_stall) begin
          if (m_out && v) begin
            m_held = 1; m_held_pc = m_out_pc; m_held_instr = d; m_out = 0;
          end
        end else begin
          if (m_out && v) begin
            deliver(m_out_pc, d); m_out = 0;
          end else if (m_held) begin
            deliver(m_held_pc, m_held_instr); m_held = 0;
          end else begin
            m_v = 0; m_instr = T_NOP;
          end
          if (acc) begin
            m_out = 1; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
          end
        end
      end

      if (v) pend = 0;
      else if (pend && !r_rst && pend_cnt > 0) pend_cnt--;
      if (acc) begin
        pend = 1; pend_addr = cur_pc;
        pend_cnt = fast ? 0 : $urandom_range(0, 5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
